// File: rtl/alu_issue.sv
// Single-issue front end for an external multi-cycle ALU: decodes one instruction
// at a time, reads the 8x16 register file, hands operands to the ALU and writes back.
module alu_issue #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_y,
  input  logic        alu_carry,
  input  logic        alu_ov,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z,
  output logic        busy,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_instr;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [4:0]  r_alu_op;
  logic        r_alu_start;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_result;
  logic        r_res_c;
  logic        r_res_v;
  logic        r_flag_c;
  logic        r_flag_v;
  logic        r_flag_z;

  logic [3:0]  w_opcode;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic        w_signed;
  logic [8:0]  w_imm;
  logic        w_illegal;
  logic        w_is_ldi;
  logic        w_b_zero;
  logic        w_upd_c;
  logic        w_upd_v;
  logic        w_wait_expired;
  logic        w_wr_en;
  logic [15:0] w_rf [0:7];

  assign w_opcode = r_instr[15:12];
  assign w_rd     = r_instr[11:9];
  assign w_rs1    = r_instr[8:6];
  assign w_rs2    = r_instr[5:3];
  assign w_signed = r_instr[2];
  assign w_imm    = r_instr[8:0];

  assign w_illegal = (w_opcode == 4'd6) || (w_opcode >= 4'd12);
  assign w_is_ldi  = (w_opcode == 4'd11);
  assign w_b_zero  = (w_opcode == 4'd4) || (w_opcode == 4'd7) || (w_opcode == 4'd8);
  assign w_upd_c   = (w_opcode == 4'd0) || (w_opcode == 4'd1) ||
                     (w_opcode == 4'd7) || (w_opcode == 4'd8);
  assign w_upd_v   = (w_opcode == 4'd0) || (w_opcode == 4'd1);

  // The last permitted WAIT cycle; a done arriving in that same cycle still wins.
  assign w_wait_expired = (r_wait_cnt == 8'(TIMEOUT - 1));
  assign w_wr_en        = (r_state == S_WB);

  // r0 is hard-wired to zero; only r1..r7 have storage.
  assign w_rf[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_rf
      logic [15:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_wr_en && (w_rd == 3'(gi))) begin
          r_q <= r_result;
        end
      end
      assign w_rf[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_start <= 1'b0;
      r_wait_cnt  <= '0;
      r_result    <= '0;
      r_res_c     <= 1'b0;
      r_res_v     <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_flag_z    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_illegal) begin
            r_state <= S_IDLE;
          end else if (w_is_ldi) begin
            r_result <= {7'b0, w_imm};
            r_state  <= S_WB;
          end else begin
            r_alu_a     <= w_rf[w_rs1];
            r_alu_b     <= w_b_zero ? 16'd0 : w_rf[w_rs2];
            r_alu_op    <= {w_signed, w_opcode};
            r_alu_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_alu_start <= 1'b0;
          r_wait_cnt  <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            r_result <= alu_y;
            r_res_c  <= alu_carry;
            r_res_v  <= alu_ov;
            r_state  <= S_WB;
          end else if (w_wait_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          // LDI never matches the C/V opcode sets, so it only touches Z.
          r_flag_z <= (r_result == 16'd0);
          if (w_upd_c) r_flag_c <= r_res_c;
          if (w_upd_v) r_flag_v <= r_res_v;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign flag_c      = r_flag_c;
  assign flag_v      = r_flag_v;
  assign flag_z      = r_flag_z;
  assign dbg_data    = w_rf[dbg_addr];
  assign err_illegal = (r_state == S_READ) && w_illegal;
  assign err_timeout = (r_state == S_WAIT) && !alu_done && w_wait_expired;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: plays the ALU side, keeps an architectural model
// (register array + flags) and checks handshakes, operands, writeback and errors.
module tb_alu_issue;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_y = '0;
  logic        alu_carry = 1'b0;
  logic        alu_ov = 1'b0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic        flag_c;
  logic        flag_v;
  logic        flag_z;
  logic        busy;
  logic        err_illegal;
  logic        err_timeout;

  alu_issue #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_y(alu_y), .alu_carry(alu_carry), .alu_ov(alu_ov),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flag_c(flag_c), .flag_v(flag_v),
    .flag_z(flag_z), .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_rf [8];
  logic        m_c, m_v, m_z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk_op(input int op, input int rd, input int rs1,
                                        input int rs2, input int sg);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 1'(sg), 2'b00};
  endfunction

  function automatic logic [15:0] mk_ldi(input int rd, input int imm);
    return {4'hB, 3'(rd), 9'(imm)};
  endfunction

  // Behavioural ALU: returns {carry, overflow, y}; carry on sub means "no borrow".
  function automatic logic [17:0] ref_alu(input logic [3:0] op, input logic sg,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] y;
    logic        c, v;
    y = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (y[15] != a[15]);
      end
      4'd1: begin
        y = a - b; c = (a >= b);
        v = (a[15] != b[15]) && (y[15] != a[15]);
      end
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = ~a;
      4'd5:    y = a ^ b;
      4'd7:    begin y = a << 1; c = a[15]; end
      4'd8:    begin y = a >> 1; c = a[0]; end
      4'd9:    y = sg ? 16'($signed(a) < $signed(b)) : 16'(a < b);
      4'd10:   y = 16'(a == b);
      default: y = '0;
    endcase
    return {c, v, y};
  endfunction

  task automatic check_state();
    chk("flag_c", 32'(flag_c), 32'(m_c));
    chk("flag_v", 32'(flag_v), 32'(m_v));
    chk("flag_z", 32'(flag_z), 32'(m_z));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("reg_r%0d", i), 32'(dbg_data), 32'(m_rf[i]));
    end
  endtask

  // delay >= TO means the ALU never answers; spurious drives done during ISSUE.
  task automatic run(input logic [15:0] ins, input int delay, input bit spurious);
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        sg;
    logic [15:0] a, b;
    logic [17:0] r;
    int          k;
    bit          fin;
    op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3]; sg = ins[2];
    $display("txn instr=0x%04h op=%0d rd=%0d delay=%0d spurious=%0d", ins, op, rd, delay, spurious);
    @(negedge clk);
    chk("ready_idle", 32'(instr_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    chk("busy_read", 32'(busy), 32'd1);
    chk("ready_read", 32'(instr_ready), 32'd0);
    if (op == 4'd6 || op >= 4'd12) begin
      chk("err_illegal", 32'(err_illegal), 32'd1);
      chk("start_illegal", 32'(alu_start), 32'd0);
      @(negedge clk);
      chk("ready_after_illegal", 32'(instr_ready), 32'd1);
      chk("err_illegal_clear", 32'(err_illegal), 32'd0);
    end else if (op == 4'd11) begin
      chk("err_illegal_ldi", 32'(err_illegal), 32'd0);
      @(negedge clk);
      chk("start_ldi", 32'(alu_start), 32'd0);
      chk("busy_wb_ldi", 32'(busy), 32'd1);
      if (rd != 3'd0) m_rf[rd] = {7'b0, ins[8:0]};
      m_z = (ins[8:0] == 9'd0);
      @(negedge clk);
      chk("ready_ldi", 32'(instr_ready), 32'd1);
    end else begin
      a = m_rf[rs1];
      b = (op == 4'd4 || op == 4'd7 || op == 4'd8) ? 16'd0 : m_rf[rs2];
      r = ref_alu(op, sg, a, b);
      chk("err_illegal_alu", 32'(err_illegal), 32'd0);
      chk("start_read", 32'(alu_start), 32'd0);
      @(negedge clk);
      chk("start_issue", 32'(alu_start), 32'd1);
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      chk("alu_op", 32'(alu_op), 32'({sg, op}));
      if (spurious) begin
        alu_done = 1'b1; alu_y = ~r[15:0];
      end
      @(negedge clk);
      alu_done = 1'b0;
      k = 0; fin = 1'b0;
      while (!fin) begin
        chk("start_wait", 32'(alu_start), 32'd0);
        chk("alu_a_hold", 32'(alu_a), 32'(a));
        chk("alu_op_hold", 32'(alu_op), 32'({sg, op}));
        if (delay < TO && k == delay) begin
          alu_done = 1'b1; alu_y = r[15:0]; alu_carry = r[17]; alu_ov = r[16];
          #1;
          chk("timeout_with_done", 32'(err_timeout), 32'd0);
          fin = 1'b1;
        end else begin
          #1;
          chk($sformatf("timeout_wait%0d", k), 32'(err_timeout), 32'(k == TO - 1));
          if (k == TO - 1) fin = 1'b1;
          else begin
            @(negedge clk);
            k++;
          end
        end
      end
      @(negedge clk);
      alu_done = 1'b0; alu_y = 16'($urandom); alu_carry = 1'($urandom); alu_ov = 1'($urandom);
      if (delay >= TO) begin
        chk("busy_after_timeout", 32'(busy), 32'd0);
        chk("ready_after_timeout", 32'(instr_ready), 32'd1);
        chk("timeout_clear", 32'(err_timeout), 32'd0);
      end else begin
        chk("busy_wb", 32'(busy), 32'd1);
        chk("ready_wb", 32'(instr_ready), 32'd0);
        if (rd != 3'd0) m_rf[rd] = r[15:0];
        m_z = (r[15:0] == 16'd0);
        if (op == 4'd0 || op == 4'd1 || op == 4'd7 || op == 4'd8) m_c = r[17];
        if (op == 4'd0 || op == 4'd1) m_v = r[16];
        @(negedge clk);
        chk("ready_after_wb", 32'(instr_ready), 32'd1);
        dbg_addr = rd;
        #1;
        chk("rd_after_wb", 32'(dbg_data), 32'(m_rf[rd]));
      end
    end
    check_state();
  endtask

  task automatic mid_reset();
    $display("txn reset during WAIT");
    @(negedge clk);
    instr = mk_op(0, 5, 1, 2, 0); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_start", 32'(alu_start), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
    chk("rst_errors", 32'({err_illegal, err_timeout}), 32'd0);
    alu_done = 1'b1; alu_y = 16'h1234;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    alu_done = 1'b0;
    chk("busy_after_reset", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
    check_state();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pick, d;
    bit sp;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_start", 32'(alu_start), 32'd0);
    chk("reset_operands", 32'({alu_a, alu_b} != 32'd0), 32'd0);
    chk("reset_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
    rst_n = 1'b1;

    run(mk_ldi(1, 5), 0, 1'b0);
    run(mk_ldi(2, 3), 0, 1'b0);
    run(mk_op(0, 3, 1, 2, 0), 1, 1'b0);
    chk("add_r3", 32'(m_rf[3]), 32'd8);
    run(mk_op(1, 4, 1, 1, 0), 0, 1'b0);
    run(mk_op(2, 5, 1, 2, 0), 0, 1'b0);
    run(16'hC000, 0, 1'b0);
    run(mk_op(0, 6, 1, 2, 0), 99, 1'b0);
    run(mk_op(0, 0, 1, 2, 0), 0, 1'b0);
    run(mk_op(0, 7, 1, 2, 0), 99, 1'b1);
    run(mk_op(7, 7, 3, 0, 0), 2, 1'b1);
    run(mk_op(3, 2, 7, 3, 0), 0, 1'b0);
    mid_reset();

    for (int n = 0; n < 150; n++) begin
      pick = int'($urandom_range(0, 15));
      d  = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 3));
      sp = ($urandom_range(0, 7) == 0);
      if (pick < 5)
        run(mk_ldi(int'($urandom_range(0, 7)), int'($urandom_range(0, 511))), 0, 1'b0);
      else
        run(mk_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1))), d, sp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max WAIT cycles for alu_done before abort (range 1-255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr_ready  output  1  issuer accepts instruction this cycle.
REQ-006 SHALL have port instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2] signed, [1:0] reserved; LDI uses [8:0] as imm.
REQ-007 SHALL have ports alu_a, alu_b  output  16  ALU operands.
REQ-008 SHALL have port alu_op  output  5  {signed, opcode} to ALU.
REQ-009 SHALL have port alu_start  output  1  one-cycle ALU request pulse.
REQ-010 SHALL have ports alu_done  input  1, alu_y  input  16, alu_carry  input  1, alu_ov  input  1  ALU response, valid when alu_done=1.
REQ-011 SHALL have ports dbg_addr  input  3, dbg_data  output  16  combinational register-file read.
REQ-012 SHALL have ports flag_c, flag_v, flag_z  output  1  status flags.
REQ-013 SHALL have ports busy  output  1, err_illegal  output  1, err_timeout  output  1  (errors are one-cycle pulses).

Function
REQ-014 SHALL hold 8x16 register file; r0 reads 0 always, writes to r0 discarded.
REQ-015 SHALL implement FSM IDLE, READ, ISSUE, WAIT, WB; instr_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-016 SHALL accept on instr_valid&instr_ready; IDLE->READ, latching instr.
REQ-017 Legal ALU opcodes: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 xor, 7 shl, 8 shr, 9 lt, 10 eq; 11 = LDI (local); 6, 12-15 illegal.
REQ-018 Illegal opcode SHALL pulse err_illegal in READ cycle, return to IDLE, no register/flag change, no alu_start.
REQ-019 LDI SHALL go READ->WB, write rd <= {7'b0, imm[8:0]}, update flag_z only, never assert alu_start.
REQ-020 READ SHALL latch alu_a=R[rs1], alu_b=R[rs2] (alu_b=0 for not/shl/shr), alu_op={signed,opcode}; outputs held stable through WAIT.
REQ-021 ISSUE SHALL assert alu_start for exactly one cycle, then enter WAIT.
REQ-022 alu_done SHALL be sampled only in WAIT; done in any other state ignored.
REQ-023 WAIT with alu_done=1 SHALL capture alu_y/carry/ov and go WB next cycle.
REQ-024 WAIT counter SHALL count cycles from WAIT entry; if TIMEOUT cycles elapse with no done, pulse err_timeout, go IDLE, no writeback, flags unchanged.
REQ-025 WB SHALL write rd, set flag_z=(result==0); flag_c updated for add/sub/shl/shr; flag_v updated for add/sub only; else C,V held; then IDLE.
REQ-026 Minimum ALU op latency: accept cycle N, alu_start N+2, done earliest N+3, rd visible on dbg_data at N+5, instr_ready high again at N+5.
REQ-027 Back-to-back dependent instruction SHALL read the value written by the preceding WB (no hazard, WB completes before next READ).

Reset
REQ-028 On rst_n=0 SHALL immediately force IDLE, registers r1-r7=0, alu_a/alu_b/alu_op=0, alu_start=0, flags=0, errors=0, busy=0, counter=0.
REQ-029 Reset mid-operation SHALL abandon instruction with no writeback; first accept possible on first clk edge after rst_n rises.

Verification
REQ-030 LDI r1,5; LDI r2,3; add r3=r1+r2 with alu_y=8 after 1 cycle -> alu_a=5, alu_b=3, alu_op=5'b00000, dbg r3=8, flag_z=0.
REQ-031 sub r4=r1-r1 response y=0,carry=1,ov=0 -> r4=0, flag_z=1, flag_c=1, flag_v=0; following and leaves flag_c=1.
REQ-032 opcode 4'hC offered -> err_illegal one pulse, no alu_start, instr_ready back high next cycle, registers unchanged.
REQ-033 alu_done held 0 in WAIT -> err_timeout pulses after exactly 15 WAIT cycles, rd unchanged, busy=0 next cycle.
REQ-034 Write rd=0 (add r0=r1+r2, y=8) -> dbg r0 reads 0; alu_done asserted during ISSUE only -> ignored, still times out.
REQ-035 rst_n low during WAIT -> outputs at reset values asynchronously, late alu_done ignored, all registers read 0.
